// File: rtl/joyport_bus_responder.sv
// Joystick/mouse bus responder: claims 68020 reads of CIA-A PRA / JOYnDAT and writes of JOYTEST.
// Latency: data driven 1 clock after AS20 is sampled low; DSACK follows 1+WAIT_STATES clocks later.
// Backpressure: none; the bus cycle length is set by AS20, and negating AS20 releases every output on the next edge.
module joyport_bus_responder #(
    parameter int NPORTS      = 2,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1,
    parameter int TEST_EN     = 1
) (
    input  logic                  CLKCPU_A,
    input  logic                  RESET,
    input  logic                  AS20,
    input  logic                  DS20,
    input  logic                  RW,
    input  logic [1:0]            SIZ,
    input  logic [23:0]           A,
    input  logic [DATA_W-1:0]     D_IN,
    output logic [DATA_W-1:0]     D_OUT,
    output logic                  D_OE,
    output logic [1:0]            DSACK_N,
    output logic                  DSACK_OE,
    input  logic                  PUNT_IN,
    output logic                  PUNT_DRIVE,
    input  logic [6*NPORTS-1:0]   JOY,
    input  logic [NPORTS-1:0]     MODE,
    input  logic [8*NPORTS-1:0]   MOUSE_DX,
    input  logic [8*NPORTS-1:0]   MOUSE_DY,
    input  logic [NPORTS-1:0]     MOUSE_STB
);

    // Word addresses (byte address >> 1) of the registers we answer for
    localparam logic [22:0] JOY0DAT_W = 23'h6FF805;   // DFF00A/B
    localparam logic [22:0] JOY1DAT_W = 23'h6FF806;   // DFF00C/D
    localparam logic [22:0] JOYTEST_W = 23'h6FF81B;   // DFF036/7
    localparam logic [23:0] CIAA_PRA  = 24'hBFE001;
    localparam logic [1:0]  ACK_CODE  = (DATA_W == 8) ? 2'b10 : 2'b01;
    localparam logic [2:0]  WAIT_LAST = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_ACK, S_SKIP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_rd;
    logic                r_wr;
    logic [DATA_W-1:0]   r_dlat;
    logic [2:0]          r_wait;
    logic [7:0]          r_xcnt [NPORTS];
    logic [7:0]          r_ycnt [NPORTS];

    logic [11:0]         w_joy_pad;
    logic                w_pra;
    logic                w_joy0;
    logic                w_joy1;
    logic                w_word_ok;
    logic                w_rd_hit;
    logic                w_wr_hit;
    logic [7:0]          w_pra_byte;
    logic [15:0]         w_word;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_claim;
    logic                w_test_load;
    logic                w_unused;

    // Zero-padded to two ports so an absent port reads as released buttons
    assign w_joy_pad  = 12'(JOY);
    assign w_pra      = (A == CIAA_PRA);
    assign w_joy0     = (A[23:1] == JOY0DAT_W);
    assign w_joy1     = (NPORTS > 1) && (A[23:1] == JOY1DAT_W);
    // A 16-bit responder only answers word-aligned JOYnDAT/JOYTEST accesses
    assign w_word_ok  = (DATA_W == 8) || !A[0];
    assign w_rd_hit   = RW && (w_pra || ((w_joy0 || w_joy1) && w_word_ok));
    assign w_wr_hit   = !RW && (TEST_EN != 0) && (A[23:1] == JOYTEST_W) && w_word_ok;
    assign w_pra_byte = {~w_joy_pad[10], ~w_joy_pad[4], 6'b000001};

    // Build the 16-bit register image for the addressed port, then pick the lane(s) we drive
    always_comb begin
        w_word = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if ((p == 0 && w_joy0) || (p == 1 && w_joy1)) begin
                if (MODE[p]) begin
                    w_word = {r_ycnt[p], r_xcnt[p]};
                end else begin
                    w_word = {6'b0, w_joy_pad[6*p+1], w_joy_pad[6*p+1] ^ w_joy_pad[6*p+3],
                              6'b0, w_joy_pad[6*p],   w_joy_pad[6*p]   ^ w_joy_pad[6*p+2]};
                end
            end
        end
        if (w_pra) begin
            w_word = (DATA_W == 16) ? {w_pra_byte, 8'h00} : {8'h00, w_pra_byte};
        end
        if (DATA_W == 16) begin
            w_rdata = w_word[DATA_W-1:0];
        end else begin
            w_rdata = A[0] ? w_word[DATA_W-1:0] : w_word[15:16-DATA_W];
        end
    end

    // Next-state logic: claim in IDLE only when nobody else has punted the cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!AS20) begin
                    if (PUNT_IN && (w_rd_hit || w_wr_hit)) w_next = S_DRIVE;
                    else                                   w_next = S_SKIP;
                end
            end
            S_DRIVE: begin
                if (AS20)                  w_next = S_IDLE;
                else if (WAIT_STATES == 0) w_next = S_ACK;
                else                       w_next = S_WAIT;
            end
            S_WAIT: begin
                if (AS20)                    w_next = S_IDLE;
                else if (r_wait == WAIT_LAST) w_next = S_ACK;
            end
            S_ACK, S_SKIP: begin
                if (AS20) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLKCPU_A) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Cycle attributes captured on the claiming edge; data stays frozen for the whole cycle
    always_ff @(posedge CLKCPU_A) begin
        if (RESET) begin
            r_rd   <= 1'b0;
            r_wr   <= 1'b0;
            r_dlat <= '0;
            r_wait <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_rd   <= RW;
                r_wr   <= !RW;
                r_dlat <= w_rdata;
            end
            r_wait <= (r_state == S_WAIT) ? r_wait + 3'd1 : 3'd0;
        end
    end

    // A JOYTEST load at the end of DRIVE overrides any mouse strobe on the same edge
    assign w_test_load = (r_state == S_DRIVE) && r_wr;

    // Mouse counters: wrapping 8-bit accumulation, upper six bits preloadable via JOYTEST
    always_ff @(posedge CLKCPU_A) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (RESET) begin
                r_xcnt[p] <= '0;
                r_ycnt[p] <= '0;
            end else if (w_test_load) begin
                r_ycnt[p][7:2] <= D_IN[DATA_W-1 -: 6];
                if (DATA_W == 16) r_xcnt[p][7:2] <= D_IN[7:2];
            end else if (MOUSE_STB[p] && MODE[p]) begin
                r_xcnt[p] <= r_xcnt[p] + MOUSE_DX[8*p +: 8];
                r_ycnt[p] <= r_ycnt[p] + MOUSE_DY[8*p +: 8];
            end
        end
    end

    assign w_claim    = (r_state == S_DRIVE) || (r_state == S_WAIT) || (r_state == S_ACK);
    assign PUNT_DRIVE = w_claim;
    assign D_OE       = w_claim && r_rd;
    assign D_OUT      = D_OE ? r_dlat : '0;
    assign DSACK_OE   = (r_state == S_ACK);
    assign DSACK_N    = DSACK_OE ? ACK_CODE : 2'b11;

    // Bus qualifiers this responder does not need
    assign w_unused = ^{DS20, SIZ, D_IN, w_joy_pad};

endmodule

// File: tb/tb_joyport_bus_responder.sv
module tb_joyport_bus_responder;

    logic        clk = 1'b0;
    logic        rst, as20, ds20, rw, punt_in;
    logic [1:0]  siz;
    logic [23:0] a;
    logic [15:0] din;
    logic [11:0] joy;
    logic [1:0]  mode, stb;
    logic [15:0] dx, dy;

    logic [7:0]  dout8;
    logic [15:0] dout16;
    logic        doe8, doe16, dsoe8, dsoe16, punt8, punt16;
    logic [1:0]  dsn8, dsn16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    joyport_bus_responder #(.NPORTS(2), .DATA_W(8), .WAIT_STATES(1), .TEST_EN(1)) u8 (
        .CLKCPU_A(clk), .RESET(rst), .AS20(as20), .DS20(ds20), .RW(rw), .SIZ(siz), .A(a),
        .D_IN(din[15:8]), .D_OUT(dout8), .D_OE(doe8), .DSACK_N(dsn8), .DSACK_OE(dsoe8),
        .PUNT_IN(punt_in), .PUNT_DRIVE(punt8), .JOY(joy), .MODE(mode),
        .MOUSE_DX(dx), .MOUSE_DY(dy), .MOUSE_STB(stb));

    joyport_bus_responder #(.NPORTS(2), .DATA_W(16), .WAIT_STATES(2), .TEST_EN(1)) u16 (
        .CLKCPU_A(clk), .RESET(rst), .AS20(as20), .DS20(ds20), .RW(rw), .SIZ(siz), .A(a),
        .D_IN(din), .D_OUT(dout16), .D_OE(doe16), .DSACK_N(dsn16), .DSACK_OE(dsoe16),
        .PUNT_IN(punt_in), .PUNT_DRIVE(punt16), .JOY(joy), .MODE(mode),
        .MOUSE_DX(dx), .MOUSE_DY(dy), .MOUSE_STB(stb));

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (index k: 0 = 8-bit/1 wait, 1 = 16-bit/2 waits)
    bit          m_started = 1'b0;
    int          m_phase [2];      // 0 no cycle, 1 claimed, 2 ignored
    int          m_n     [2];      // edges since the claiming edge
    bit          m_rd    [2];
    bit          m_wr    [2];
    logic [15:0] m_data  [2];
    logic [7:0]  mx [2][2];
    logic [7:0]  my [2][2];
    logic        e_punt [2];
    logic        e_oe   [2];
    logic        e_dsoe [2];
    logic [15:0] e_dout [2];
    logic [1:0]  e_dsn  [2];

    function automatic bit m_hit(int k, logic [23:0] ad, logic rd);
        if (rd) begin
            if (k == 0) return ad inside {24'hBFE001, 24'hDFF00A, 24'hDFF00B, 24'hDFF00C, 24'hDFF00D};
            return ad inside {24'hBFE001, 24'hDFF00A, 24'hDFF00C};
        end
        if (k == 0) return ad inside {24'hDFF036, 24'hDFF037};
        return ad == 24'hDFF036;
    endfunction

    function automatic logic [15:0] m_read(int k, logic [23:0] ad);
        logic [15:0] w;
        logic [7:0]  b;
        int          p;
        b = {~joy[10], ~joy[4], 6'b000001};
        if (ad == 24'hBFE001) return (k == 0) ? {8'h00, b} : {b, 8'h00};
        p = (ad == 24'hDFF00C || ad == 24'hDFF00D) ? 1 : 0;
        if (mode[p]) begin
            w = {my[k][p], mx[k][p]};
        end else begin
            w = 16'h0000;
            w[9] = joy[6*p+1];
            w[8] = joy[6*p+1] ^ joy[6*p+3];
            w[1] = joy[6*p];
            w[0] = joy[6*p] ^ joy[6*p+2];
        end
        if (k == 1) return w;
        return ad[0] ? {8'h00, w[7:0]} : {8'h00, w[15:8]};
    endfunction

    always @(posedge clk) begin
        bit load;
        int ws;
        if (rst) m_started = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ws = (k == 0) ? 1 : 2;
            if (rst) begin
                m_phase[k] = 0;
                m_n[k] = 0;
                for (int p = 0; p < 2; p++) begin
                    mx[k][p] = 8'h00;
                    my[k][p] = 8'h00;
                end
            end else begin
                load = (m_phase[k] == 1) && (m_n[k] == 0) && m_wr[k];
                if (m_phase[k] == 0) begin
                    if (!as20) begin
                        if (punt_in && m_hit(k, a, rw)) begin
                            m_phase[k] = 1;
                            m_n[k] = 0;
                            m_rd[k] = rw;
                            m_wr[k] = !rw;
                            m_data[k] = m_read(k, a);
                        end else begin
                            m_phase[k] = 2;
                        end
                    end
                end else if (as20) begin
                    m_phase[k] = 0;
                end else if (m_phase[k] == 1 && m_n[k] < 1000) begin
                    m_n[k] = m_n[k] + 1;
                end
                for (int p = 0; p < 2; p++) begin
                    if (load) begin
                        my[k][p] = {din[15:10], my[k][p][1:0]};
                        if (k == 1) mx[k][p] = {din[7:2], mx[k][p][1:0]};
                    end else if (stb[p] && mode[p]) begin
                        mx[k][p] = mx[k][p] + dx[8*p +: 8];
                        my[k][p] = my[k][p] + dy[8*p +: 8];
                    end
                end
            end
            e_punt[k] = (m_phase[k] == 1);
            e_oe[k]   = e_punt[k] && m_rd[k];
            e_dout[k] = e_oe[k] ? m_data[k] : 16'h0000;
            e_dsoe[k] = e_punt[k] && (m_n[k] >= 1 + ws);
            e_dsn[k]  = e_dsoe[k] ? ((k == 0) ? 2'b10 : 2'b01) : 2'b11;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_started) begin
            check("u8 PUNT_DRIVE",  {15'b0, punt8},  {15'b0, e_punt[0]});
            check("u8 D_OE",        {15'b0, doe8},   {15'b0, e_oe[0]});
            check("u8 D_OUT",       {8'h00, dout8},  e_dout[0]);
            check("u8 DSACK_OE",    {15'b0, dsoe8},  {15'b0, e_dsoe[0]});
            check("u8 DSACK_N",     {14'b0, dsn8},   {14'b0, e_dsn[0]});
            check("u16 PUNT_DRIVE", {15'b0, punt16}, {15'b0, e_punt[1]});
            check("u16 D_OE",       {15'b0, doe16},  {15'b0, e_oe[1]});
            check("u16 D_OUT",      dout16,          e_dout[1]);
            check("u16 DSACK_OE",   {15'b0, dsoe16}, {15'b0, e_dsoe[1]});
            check("u16 DSACK_N",    {14'b0, dsn16},  {14'b0, e_dsn[1]});
        end
    end

    // ---------------- directed bus-cycle driver
    logic [15:0] res_d8, res_d16;
    logic [1:0]  res_c8, res_c16;
    int          res_drv8, res_ack8, res_drv16, res_ack16;
    bit          res_any, res_clean;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_stb(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y);
        stb = m; dx = x; dy = y;
        tick();
        stb = 2'b00; dx = 16'h0; dy = 16'h0;
    endtask

    task automatic bus_cycle(input logic [23:0] ad, input logic rw_i, input logic punt_i,
                             input int hold, input bit stb_drv);
        a = ad; rw = rw_i; punt_in = punt_i; as20 = 1'b0; ds20 = 1'b0;
        res_d8 = 16'h0; res_d16 = 16'h0; res_c8 = 2'b11; res_c16 = 2'b11;
        res_drv8 = -1; res_ack8 = -1; res_drv16 = -1; res_ack16 = -1; res_any = 1'b0;
        for (int c = 1; c <= hold; c++) begin
            tick();
            if (stb_drv) begin
                if (c == 1) begin stb = 2'b01; dx = 16'h0001; dy = 16'h0000; end
                else stb = 2'b00;
            end
            if (punt8 || doe8 || dsoe8 || punt16 || doe16 || dsoe16) res_any = 1'b1;
            if (punt8  && res_drv8  < 0) res_drv8  = c;
            if (dsoe8  && res_ack8  < 0) res_ack8  = c;
            if (punt16 && res_drv16 < 0) res_drv16 = c;
            if (dsoe16 && res_ack16 < 0) res_ack16 = c;
            if (doe8)   res_d8  = {8'h00, dout8};
            if (doe16)  res_d16 = dout16;
            if (dsoe8)  res_c8  = dsn8;
            if (dsoe16) res_c16 = dsn16;
        end
        as20 = 1'b1; ds20 = 1'b1; stb = 2'b00;
        tick();
        res_clean = !(punt8 || doe8 || dsoe8 || punt16 || doe16 || dsoe16);
        tick();
    endtask

    logic [23:0] addrs [10] = '{24'hBFE001, 24'hDFF00A, 24'hDFF00B, 24'hDFF00C, 24'hDFF00D,
                                24'hDFF036, 24'hDFF037, 24'hDFF00E, 24'hBFE101, 24'hDFF008};

    initial begin
        rst = 1'b1; as20 = 1'b1; ds20 = 1'b1; rw = 1'b1; punt_in = 1'b1; siz = 2'b01;
        a = 24'h0; din = 16'h0; joy = 12'h0; mode = 2'b11; stb = 2'b00; dx = 16'h0; dy = 16'h0;
        tick(); tick();
        check("reset DSACK_OE", {14'b0, dsoe8, dsoe16}, 16'h0);
        check("reset D_OE",     {14'b0, doe8, doe16},   16'h0);
        check("reset PUNT",     {14'b0, punt8, punt16}, 16'h0);
        check("reset DSACK_N",  {12'b0, dsn8, dsn16},   16'h000F);
        check("reset D_OUT",    {8'h00, dout8} | dout16, 16'h0);
        rst = 1'b0;
        tick();

        bus_cycle(24'hDFF00A, 1, 1, 6, 0);
        check("rd0 u8 data",  res_d8,  16'h0000);
        check("rd0 u16 data", res_d16, 16'h0000);
        check("rd0 u8 ack lat",  16'(res_ack8 - res_drv8),   16'd2);
        check("rd0 u16 ack lat", 16'(res_ack16 - res_drv16), 16'd3);
        check("rd0 u8 DSACK_N",  {14'b0, res_c8},  16'h0002);
        check("rd0 u16 DSACK_N", {14'b0, res_c16}, 16'h0001);

        pulse_stb(2'b01, 16'h0005, 16'h00FE);
        bus_cycle(24'hDFF00A, 1, 1, 6, 0);
        check("mouse u8 even", res_d8,  16'h00FE);
        check("mouse u16",     res_d16, 16'hFE05);
        bus_cycle(24'hDFF00B, 1, 1, 6, 0);
        check("mouse u8 odd",       res_d8, 16'h0005);
        check("u16 odd word skipped", 16'(res_drv16), 16'hFFFF);

        pulse_stb(2'b01, 16'h00F9, 16'h0000);
        pulse_stb(2'b01, 16'h0003, 16'h0000);
        bus_cycle(24'hDFF00B, 1, 1, 6, 0);
        check("wrap FE+03 u8", res_d8, 16'h0001);
        pulse_stb(2'b01, 16'h00FE, 16'h0000);
        bus_cycle(24'hDFF00B, 1, 1, 6, 0);
        check("wrap 01+FE u8", res_d8, 16'h00FF);
        bus_cycle(24'hDFF00A, 1, 1, 6, 0);
        check("wrap 01+FE u16", res_d16, 16'hFEFF);

        mode = 2'b01; joy = 12'h280;
        pulse_stb(2'b10, 16'h1100, 16'h2200);
        bus_cycle(24'hDFF00C, 1, 1, 6, 0);
        check("joy1 L+U u16",  res_d16, 16'h0200);
        check("joy1 L+U u8",   res_d8,  16'h0002);
        check("joy1 u16 DSACK_N", {14'b0, res_c16}, 16'h0001);
        joy = 12'h290;
        bus_cycle(24'hBFE001, 1, 1, 6, 0);
        check("pra fire0 u8",  res_d8,  16'h0081);
        check("pra fire0 u16", res_d16, 16'h8100);

        bus_cycle(24'hDFF00A, 1, 0, 6, 0);
        check("punted no outputs", {15'b0, res_any}, 16'h0);

        bus_cycle(24'hDFF00A, 1, 1, 2, 0);
        check("abort u8 no ack",  16'(res_ack8),  16'hFFFF);
        check("abort u16 no ack", 16'(res_ack16), 16'hFFFF);
        check("abort released",   {15'b0, res_clean}, 16'h0001);

        bus_cycle(24'hDFF00B, 1, 1, 6, 1);
        check("strobe in drive pre u8", res_d8, 16'h00FF);
        bus_cycle(24'hDFF00A, 1, 1, 6, 1);
        check("strobe in drive pre u16", res_d16, 16'hFE00);
        bus_cycle(24'hDFF00B, 1, 1, 6, 0);
        check("strobe post u8", res_d8, 16'h0001);
        bus_cycle(24'hDFF00A, 1, 1, 6, 0);
        check("strobe post u16", res_d16, 16'hFE01);

        din = 16'hABCD;
        bus_cycle(24'hDFF036, 0, 1, 6, 1);
        check("joytest u8 ack lat", 16'(res_ack8 - res_drv8), 16'd2);
        bus_cycle(24'hDFF00A, 1, 1, 6, 0);
        check("joytest u16 load", res_d16, 16'hAACD);
        check("joytest u8 Y",     res_d8,  16'h00AA);
        bus_cycle(24'hDFF00B, 1, 1, 6, 0);
        check("joytest u8 X kept", res_d8, 16'h0001);

        // Randomized traffic checked cycle by cycle against the model
        for (int it = 0; it < 300; it++) begin
            int hold;
            a = addrs[$urandom_range(0, 9)];
            rw = (a == 24'hDFF036 || a == 24'hDFF037) ? 1'($urandom_range(0, 1))
                                                      : 1'($urandom_range(0, 3) != 0);
            punt_in = ($urandom_range(0, 7) != 0);
            din = 16'($urandom);
            hold = $urandom_range(1, 7);
            as20 = 1'b0; ds20 = 1'b0;
            for (int c = 0; c < hold; c++) begin
                stb = 2'($urandom); dx = 16'($urandom); dy = 16'($urandom);
                mode = 2'($urandom); joy = 12'($urandom);
                rst = ($urandom_range(0, 59) == 0);
                tick();
            end
            rst = 1'b0;
            as20 = 1'b1; ds20 = 1'b1;
            for (int c = 0; c <= int'($urandom_range(0, 2)); c++) begin
                stb = 2'($urandom); dx = 16'($urandom); dy = 16'($urandom);
                tick();
            end
        end
        stb = 2'b00;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
